// File: rtl/rv32_pkg.sv
// Shared RV32I writeback encodings: result-source selects, load funct3 codes and stage states.
package rv32_pkg;

    localparam logic [1:0] WB_SEL_NONE = 2'd0;
    localparam logic [1:0] WB_SEL_ALU  = 2'd1;
    localparam logic [1:0] WB_SEL_LOAD = 2'd2;
    localparam logic [1:0] WB_SEL_PC4  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic {IDLE, WAIT_MEM} wb_state_t;

    // Undefined load encodings fall into the word-access rule.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: load_misaligned = 1'b0;
            F3_LH, F3_LHU: load_misaligned = addr_lo[0];
            default:       load_misaligned = (addr_lo != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the byte/half addressed by addr_lo, sign/zero-extends it,
// and flags accesses that are not naturally aligned.
module wb_load_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

    assign misalign = load_misaligned(funct3, addr_lo);

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage driving the register-file write port; sole writer of the regfile.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
//
//   state    | meaning
//   IDLE     | ready for a new instruction; ALU/PC4/NONE retire immediately
//   WAIT_MEM | load accepted, waiting for mem_rvalid to write aligned data
module wb_stage
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
`ifdef WB_INSTRET_EN
    , parameter int INSTRET_W = 64
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_pc4,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            w_enable,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            ld_misalign,
    output logic            busy
`ifdef WB_INSTRET_EN
    , output logic [INSTRET_W-1:0] instret
`endif
);

    wb_state_t       state;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [XLEN-1:0] al_result;
    logic            al_misalign;

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_MEM);

    // In IDLE the aligner only screens the incoming load; in WAIT_MEM it shapes the returned data.
    assign al_funct3  = in_ready ? in_funct3  : ld_funct3;
    assign al_addr_lo = in_ready ? in_addr_lo : ld_addr_lo;

    wb_load_align u_align (
        .funct3   (al_funct3),
        .addr_lo  (al_addr_lo),
        .rdata    (mem_rdata),
        .result   (al_result),
        .misalign (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            w_enable    <= 1'b0;
            wb_addr     <= 5'd0;
            wb_data     <= '0;
            ld_misalign <= 1'b0;
            ld_rd       <= 5'd0;
            ld_funct3   <= 3'd0;
            ld_addr_lo  <= 2'd0;
        end else begin
            w_enable    <= 1'b0;
            ld_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        case (in_wb_sel)
                            WB_SEL_ALU, WB_SEL_PC4: begin
                                // x0 writes are dropped entirely so the port keeps its last value
                                if (in_rd != 5'd0) begin
                                    w_enable <= 1'b1;
                                    wb_addr  <= in_rd;
                                    wb_data  <= (in_wb_sel == WB_SEL_ALU) ? in_alu_res : in_pc4;
                                end
                            end
                            WB_SEL_LOAD: begin
                                if (al_misalign) begin
                                    ld_misalign <= 1'b1;
                                end else begin
                                    ld_rd      <= in_rd;
                                    ld_funct3  <= in_funct3;
                                    ld_addr_lo <= in_addr_lo;
                                    state      <= WAIT_MEM;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        if (ld_rd != 5'd0) begin
                            w_enable <= 1'b1;
                            wb_addr  <= ld_rd;
                            wb_data  <= al_result;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        if (state == IDLE)
            retire = in_valid && (in_wb_sel != WB_SEL_LOAD);
        else
            retire = mem_rvalid;
    end

    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (retire)
            instret <= instret + 1'b1;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-cycle retirements, hand sequences for loads.
module tb_wb_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        w_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ld_misalign;
    logic        busy;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_instret = 64'd0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_wb_sel   (in_wb_sel),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .in_alu_res  (in_alu_res),
        .in_pc4      (in_pc4),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .w_enable    (w_enable),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ld_misalign (ld_misalign),
        .busy        (busy)
`ifdef WB_INSTRET_EN
        , .instret   (instret)
`endif
    );

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
        logic        retire;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_instret(input string name);
`ifdef WB_INSTRET_EN
        check(name, instret, exp_instret);
`endif
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [1:0] lo, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp);
        in_valid   = 1'b1;
        in_wb_sel  = WB_SEL_LOAD;
        in_rd      = rd;
        in_funct3  = f3;
        in_addr_lo = lo;
        mem_rvalid = 1'b1;          // same-cycle data must not be consumed
        mem_rdata  = 32'h5555_5555;
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        check({name, "_busy0"}, busy, 1);
        check({name, "_ready0"}, in_ready, 0);
        check({name, "_we0"}, w_enable, 0);
        for (int w = 0; w < waits; w++) begin
            in_valid   = (w == 0);  // offered while busy: must be ignored
            in_wb_sel  = WB_SEL_ALU;
            in_rd      = 5'd20;
            in_alu_res = 32'hBAD0_BAD0;
            tick();
            in_valid = 1'b0;
            check({name, "_wait_busy"}, busy, 1);
            check({name, "_wait_we"}, w_enable, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        exp_instret++;
        check({name, "_we"}, w_enable, 1);
        check({name, "_addr"}, wb_addr, rd);
        check({name, "_data"}, wb_data, exp);
        check({name, "_ready"}, in_ready, 1);
        tick();
        check({name, "_pulse"}, w_enable, 0);
    endtask

    initial begin
        // sel, rd, f3, lo, alu, pc4, we, addr, data, mis, retire
        vecs[0] = '{WB_SEL_ALU,  5'd5,  3'd0,   2'd0, 32'h1234_5678, 32'h0,         1'b1, 5'd5,  32'h1234_5678, 1'b0, 1'b1};
        vecs[1] = '{WB_SEL_PC4,  5'd31, 3'd0,   2'd0, 32'hDEAD_BEEF, 32'h0000_0104, 1'b1, 5'd31, 32'h0000_0104, 1'b0, 1'b1};
        vecs[2] = '{WB_SEL_ALU,  5'd0,  3'd0,   2'd0, 32'hFFFF_FFFF, 32'h0,         1'b0, 5'd31, 32'h0000_0104, 1'b0, 1'b1};
        vecs[3] = '{WB_SEL_NONE, 5'd7,  3'd0,   2'd0, 32'h7777_7777, 32'h0,         1'b0, 5'd31, 32'h0000_0104, 1'b0, 1'b1};
        vecs[4] = '{WB_SEL_LOAD, 5'd9,  F3_LHU, 2'd1, 32'h0,         32'h0,         1'b0, 5'd31, 32'h0000_0104, 1'b1, 1'b0};
        vecs[5] = '{WB_SEL_LOAD, 5'd9,  F3_LW,  2'd2, 32'h0,         32'h0,         1'b0, 5'd31, 32'h0000_0104, 1'b1, 1'b0};
        vecs[6] = '{WB_SEL_LOAD, 5'd9,  F3_LH,  2'd3, 32'h0,         32'h0,         1'b0, 5'd31, 32'h0000_0104, 1'b1, 1'b0};
        vecs[7] = '{WB_SEL_LOAD, 5'd9,  3'b111, 2'd1, 32'h0,         32'h0,         1'b0, 5'd31, 32'h0000_0104, 1'b1, 1'b0};
        vecs[8] = '{WB_SEL_ALU,  5'd1,  3'd0,   2'd0, 32'h0,         32'h0,         1'b1, 5'd1,  32'h0000_0000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_wb_sel = WB_SEL_NONE; in_funct3 = 3'd0;
        in_addr_lo = 2'd0; in_alu_res = 32'h0; in_pc4 = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        check("rst_we", w_enable, 0);
        check("rst_addr", wb_addr, 0);
        check("rst_data", wb_data, 0);
        check("rst_mis", ld_misalign, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check_instret("rst_instret");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            in_valid   = 1'b1;
            in_wb_sel  = vecs[i].sel;
            in_rd      = vecs[i].rd;
            in_funct3  = vecs[i].f3;
            in_addr_lo = vecs[i].lo;
            in_alu_res = vecs[i].alu;
            in_pc4     = vecs[i].pc4;
            tick();
            in_valid = 1'b0;
            if (vecs[i].retire) exp_instret++;
            check($sformatf("vec%0d_we", i), w_enable, vecs[i].we);
            check($sformatf("vec%0d_addr", i), wb_addr, vecs[i].addr);
            check($sformatf("vec%0d_data", i), wb_data, vecs[i].data);
            check($sformatf("vec%0d_mis", i), ld_misalign, vecs[i].mis);
            check($sformatf("vec%0d_ready", i), in_ready, 1);
            tick();
            check($sformatf("vec%0d_we_pulse", i), w_enable, 0);
            check($sformatf("vec%0d_mis_pulse", i), ld_misalign, 0);
        end
        check_instret("table_instret");

        do_load("lb",   F3_LB,  5'd3,  2'd3, 32'h80FF_0000, 2, 32'hFFFF_FF80);
        do_load("lbu",  F3_LBU, 5'd3,  2'd3, 32'h80FF_0000, 2, 32'h0000_0080);
        do_load("lh",   F3_LH,  5'd6,  2'd2, 32'h8001_1234, 1, 32'hFFFF_8001);
        do_load("lhu",  F3_LHU, 5'd7,  2'd0, 32'h8001_F234, 0, 32'h0000_F234);
        do_load("lw",   F3_LW,  5'd8,  2'd0, 32'hCAFE_BABE, 1, 32'hCAFE_BABE);
        do_load("lb1",  F3_LB,  5'd9,  2'd1, 32'h0000_7F00, 1, 32'h0000_007F);
        do_load("f3_3", 3'b011, 5'd11, 2'd0, 32'h1234_5678, 1, 32'h1234_5678);
        check_instret("load_instret");

        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        check("idle_rvalid_we", w_enable, 0);
        check("idle_rvalid_busy", busy, 0);
        check("idle_rvalid_data", wb_data, 32'h1234_5678);

        for (int j = 0; j < 3; j++) begin
            in_valid   = 1'b1;
            in_wb_sel  = (j == 1) ? WB_SEL_PC4 : WB_SEL_ALU;
            in_rd      = 5'd10 + 5'(j);
            in_alu_res = 32'hA000_0000 + 32'(j);
            in_pc4     = 32'h0000_1000 + 32'(j);
            tick();
            exp_instret++;
            check($sformatf("b2b%0d_we", j), w_enable, 1);
            check($sformatf("b2b%0d_addr", j), wb_addr, 5'd10 + 5'(j));
            check($sformatf("b2b%0d_data", j), wb_data,
                  (j == 1) ? 32'h0000_1001 : 32'hA000_0000 + 32'(j));
        end
        in_valid = 1'b0;
        tick();
        check("b2b_end_we", w_enable, 0);
        check_instret("b2b_instret");

        in_valid   = 1'b1;
        in_wb_sel  = WB_SEL_LOAD;
        in_rd      = 5'd4;
        in_funct3  = F3_LW;
        in_addr_lo = 2'd0;
        tick();
        in_valid = 1'b0;
        check("rstw_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_instret = 64'd0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        check("rstw_we", w_enable, 0);
        check("rstw_addr", wb_addr, 0);
        check("rstw_data", wb_data, 0);
        check("rstw_ready", in_ready, 1);
        check("rstw_busy0", busy, 0);
        tick();
        mem_rvalid = 1'b0;
        check("rstw_we2", w_enable, 0);
        check_instret("rstw_instret");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
